// File: rtl/wr_dest_sched.sv
// wr_dest_sched
//   Destination-register select for the multicycle datapath, extended with a
//   DEPTH-stage in-flight write pipeline and a per-register pending-write
//   scoreboard used to detect read-after-write hazards at issue.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (0 = reset)
//   selector   destination select: 00 rt, 01 SP_IDX, 10 RA_IDX, 11 rd
//   rt_idx     instruction[20:16]
//   rd_idx     instruction[15:11]
//   issue      request to launch an instruction that writes a register
//   src_a      first source index to check (rs)
//   src_b      second source index to check (rt)
//   flush      discard all in-flight writes
//   dest_idx   combinational selected destination
//   hazard     combinational; a nonzero source has a pending write
//   issue_ack  combinational; issue & ~hazard & ~flush
//   wb_valid   registered; write-back slot valid this cycle
//   wb_idx     registered; destination index of the write-back slot
//   busy       registered; any register has a pending write
module wr_dest_sched #(
  parameter int ADDR_W = 5,
  parameter int SP_IDX = 29,
  parameter int RA_IDX = 31,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        selector,
  input  logic [ADDR_W-1:0] rt_idx,
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic              issue,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              flush,
  output logic [ADDR_W-1:0] dest_idx,
  output logic              hazard,
  output logic              issue_ack,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_idx,
  output logic              busy
);

  localparam int NREG = 1 << ADDR_W;

  function automatic logic [ADDR_W-1:0] sel_dest(input logic [1:0]        sel,
                                                 input logic [ADDR_W-1:0] rt,
                                                 input logic [ADDR_W-1:0] rd);
    logic [ADDR_W-1:0] r;
    case (sel)
      2'b00:   r = rt;
      2'b01:   r = ADDR_W'(SP_IDX);
      2'b10:   r = ADDR_W'(RA_IDX);
      default: r = rd;
    endcase
    return r;
  endfunction

  logic              vld_p [DEPTH];
  logic [ADDR_W-1:0] idx_p [DEPTH];
  logic [CNT_W-1:0]  cnt     [NREG];
  logic [CNT_W-1:0]  cnt_nxt [NREG];
  logic              busy_q;
  logic              hz_a;
  logic              hz_b;
  logic              acc_nz;
  logic              any_nxt;

  assign dest_idx  = sel_dest(selector, rt_idx, rd_idx);
  assign hz_a      = (src_a != '0) && (cnt[src_a] != '0);
  assign hz_b      = (src_b != '0) && (cnt[src_b] != '0);
  assign hazard    = hz_a | hz_b;
  assign issue_ack = issue & ~hazard & ~flush;
  // Writes to $zero are acknowledged but never tracked or written back.
  assign acc_nz    = issue_ack && (dest_idx != '0);

  assign wb_valid = vld_p[DEPTH-1];
  assign wb_idx   = idx_p[DEPTH-1];
  assign busy     = busy_q;

  // Scoreboard next state: +1 on accepted issue, -1 as a write-back retires.
  // A same-index increment and decrement at one edge cancel out.
  always_comb begin
    any_nxt = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = '0;
      if (i != 0 && !flush) begin
        cnt_nxt[i] = cnt[i]
                   + CNT_W'(acc_nz && (dest_idx == ADDR_W'(i)))
                   - CNT_W'(wb_valid && (wb_idx == ADDR_W'(i)));
      end
      if (cnt_nxt[i] != '0) any_nxt = 1'b1;
    end
  end

  // Stage p0 .. p[DEPTH-1]: in-flight writes shift one stage per cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_p[i] <= 1'b0;
        idx_p[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_p[i] <= 1'b0;
        idx_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= acc_nz;
      idx_p[0] <= acc_nz ? dest_idx : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        idx_p[i] <= idx_p[i-1];
      end
    end
  end

  // Scoreboard and busy register; busy tracks the counters' next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      busy_q <= any_nxt;
    end
  end

endmodule

// File: tb/tb_wr_dest_sched.sv
module tb_wr_dest_sched;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] selector;
  logic [4:0] rt_idx, rd_idx, src_a, src_b;
  logic       issue, flush;
  logic [4:0] dest_idx, wb_idx;
  logic       hazard, issue_ack, wb_valid, busy;

  wr_dest_sched #(.ADDR_W(5), .SP_IDX(29), .RA_IDX(31), .DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .selector(selector), .rt_idx(rt_idx), .rd_idx(rd_idx),
    .issue(issue), .src_a(src_a), .src_b(src_b), .flush(flush),
    .dest_idx(dest_idx), .hazard(hazard), .issue_ack(issue_ack),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntot  = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         due;
    logic [4:0] idx;
  } wb_t;
  wb_t q[$];

  typedef struct {
    logic [1:0] sel;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] exp_dest;
  } sel_vec_t;
  sel_vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic drive(input logic [1:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic i, input logic [4:0] a, input logic [4:0] b,
                       input logic f);
    @(posedge clk); #1;
    selector = s; rt_idx = t; rd_idx = d; issue = i; src_a = a; src_b = b; flush = f;
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b);
    drive(2'b00, 5'd0, 5'd0, 1'b0, a, b, 1'b0);
  endtask

  task automatic expect_wb(input logic [4:0] idx);
    wb_t e;
    e.due = cyc + DEPTH;
    e.idx = idx;
    q.push_back(e);
  endtask

  // Drop expected write-backs that a flush/reset in this cycle discards;
  // one due in this very cycle is already on the outputs and stays.
  task automatic purge();
    wb_t keep[$];
    foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
    q = keep;
  endtask

  // Scoreboard monitor: every cycle, wb must match the queue head exactly
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("wb_valid_pulse", wb_valid, 1);
        chk("wb_idx", wb_idx, q[0].idx);
        void'(q.pop_front());
      end else begin
        chk("wb_valid_idle", wb_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b00, 5'd5,  5'd12, 5'd5};
    vt[1] = '{2'b01, 5'd5,  5'd12, 5'd29};
    vt[2] = '{2'b10, 5'd5,  5'd12, 5'd31};
    vt[3] = '{2'b11, 5'd5,  5'd12, 5'd12};
    vt[4] = '{2'b00, 5'd17, 5'd3,  5'd17};
    vt[5] = '{2'b11, 5'd17, 5'd3,  5'd3};
    vt[6] = '{2'b01, 5'd0,  5'd0,  5'd29};
    vt[7] = '{2'b10, 5'd0,  5'd0,  5'd31};

    reset = 1'b0; selector = 2'b00; rt_idx = '0; rd_idx = '0;
    issue = 1'b0; src_a = '0; src_b = '0; flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 issue = 1'b1; src_a = 5'd7; src_b = 5'd9;
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_idx", wb_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_issue_ack", issue_ack, 1);
    @(posedge clk); #1;
    reset = 1'b1; issue = 1'b0; src_a = '0; src_b = '0;
    mon_en = 1'b1;

    // Select sweep: purely combinational
    for (int i = 0; i < 8; i++) begin
      selector = vt[i].sel; rt_idx = vt[i].rt; rd_idx = vt[i].rd;
      #1;
      chk("dest_idx_sweep", dest_idx, vt[i].exp_dest);
    end

    // Latency and busy window
    drive(2'b11, 5'd5, 5'd12, 1'b1, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("lat_issue_ack", issue_ack, 1);
    expect_wb(5'd12);
    for (int k = 1; k <= 4; k++) begin
      idle(5'd0, 5'd0);
      @(negedge clk);
      chk("lat_busy", busy, (k <= 3) ? 1 : 0);
    end

    // RAW stall on register 8, retry issue to 9 until accepted
    drive(2'b11, 5'd0, 5'd8, 1'b1, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("raw_first_ack", issue_ack, 1);
    expect_wb(5'd8);
    for (int k = 1; k <= 4; k++) begin
      drive(2'b11, 5'd0, 5'd9, 1'b1, 5'd8, 5'd0, 1'b0);
      @(negedge clk);
      chk("raw_hazard", hazard, (k <= 3) ? 1 : 0);
      chk("raw_issue_ack", issue_ack, (k <= 3) ? 0 : 1);
      if (k == 4) expect_wb(5'd9);
    end
    idle(5'd0, 5'd9);
    @(negedge clk);
    chk("raw_src_b_hazard", hazard, 1);
    idle(5'd0, 5'd0);
    @(negedge clk);
    chk("raw_zero_src_hazard", hazard, 0);
    repeat (3) idle(5'd0, 5'd0);

    // Back-to-back writes to 31, fourth issued during the first write-back
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("b2b_ack", issue_ack, 1);
      expect_wb(5'd31);
    end
    drive(2'b10, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("b2b_ack_during_wb", issue_ack, 1);
    expect_wb(5'd31);
    for (int k = 4; k <= 7; k++) begin
      idle(5'd31, 5'd0);
      @(negedge clk);
      chk("b2b_hazard", hazard, (k <= 6) ? 1 : 0);
      chk("b2b_busy", busy, (k <= 6) ? 1 : 0);
    end

    // Write to $zero: acknowledged, no write-back, not busy
    drive(2'b00, 5'd0, 5'd12, 1'b1, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("zero_ack", issue_ack, 1);
    for (int k = 0; k < 4; k++) begin
      idle(5'd0, 5'd0);
      @(negedge clk);
      chk("zero_busy", busy, 0);
    end

    // Flush with two writes in flight and a competing issue
    drive(2'b11, 5'd0, 5'd12, 1'b1, 5'd0, 5'd0, 1'b0);
    expect_wb(5'd12);
    drive(2'b11, 5'd0, 5'd13, 1'b1, 5'd0, 5'd0, 1'b0);
    expect_wb(5'd13);
    drive(2'b11, 5'd0, 5'd14, 1'b1, 5'd12, 5'd0, 1'b1);
    purge();
    @(negedge clk);
    chk("flush_issue_ack", issue_ack, 0);
    idle(5'd12, 5'd13);
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_hazard", hazard, 0);

    // Flush in the write-back cycle: that write-back is still presented
    drive(2'b11, 5'd0, 5'd20, 1'b1, 5'd0, 5'd0, 1'b0);
    expect_wb(5'd20);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd20, 5'd0, 1'b1);
    purge();
    @(negedge clk);
    chk("flush_wb_cycle_hazard", hazard, 1);
    idle(5'd20, 5'd0);
    @(negedge clk);
    chk("flush_wb_busy", busy, 0);
    chk("flush_wb_hazard", hazard, 0);

    // Same scenario with reset instead of flush
    drive(2'b11, 5'd0, 5'd12, 1'b1, 5'd0, 5'd0, 1'b0);
    expect_wb(5'd12);
    drive(2'b11, 5'd0, 5'd13, 1'b1, 5'd0, 5'd0, 1'b0);
    expect_wb(5'd13);
    drive(2'b11, 5'd0, 5'd14, 1'b1, 5'd12, 5'd0, 1'b0);
    reset = 1'b0;
    purge();
    @(negedge clk);
    chk("rst_mid_issue_ack", issue_ack, 0);
    idle(5'd12, 5'd13);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hazard", hazard, 0);
    chk("rst_mid_wb_idx", wb_idx, 0);

    repeat (DEPTH + 2) idle(5'd0, 5'd0);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
